conv3x3_mac: RTL and testbench

Pipelined 3x3 convolution engine that consumes the nine-pixel window and `window_valid` produced by the 3x3 sliding-window stage. It produces one rectified, rescaled 8-bit feature-map pixel per valid window. Kernel weights and bias are loaded serially through a small load port into a shadow bank and committed atomically, so a kernel can be swapped mid-stream without tearing. The block sits between the window generator and the feature-map writer / pooling stage.

---
 rtl/conv3x3_mac_if.sv | 31 +++
 rtl/conv3x3_mac.sv | 145 ++++++++++++++
 tb/tb_conv3x3_mac.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv3x3_mac_if.sv
// Window/kernel-load/result bundle between the sliding-window stage,
// the kernel loader and the 3x3 convolution engine.
interface conv3x3_mac_if #(
    parameter int BIAS_W = 16
);
    logic                     en;
    logic [7:0]               w00, w01, w02;
    logic [7:0]               w10, w11, w12;
    logic [7:0]               w20, w21, w22;
    logic                     window_valid;
    logic                     wt_valid;
    logic signed [7:0]        wt_data;
    logic                     bias_valid;
    logic signed [BIAS_W-1:0] bias_data;
    logic                     weights_loaded;
    logic [3:0]               wt_idx;
    logic [7:0]               out_pixel;
    logic                     out_valid;

    modport master (
        output en, w00, w01, w02, w10, w11, w12, w20, w21, w22,
        output window_valid, wt_valid, wt_data, bias_valid, bias_data,
        input  weights_loaded, wt_idx, out_pixel, out_valid
    );

    modport slave (
        input  en, w00, w01, w02, w10, w11, w12, w20, w21, w22,
        input  window_valid, wt_valid, wt_data, bias_valid, bias_data,
        output weights_loaded, wt_idx, out_pixel, out_valid
    );
endinterface

// File: rtl/conv3x3_mac.sv
// Three-stage pipelined 3x3 convolution: products, row sums, then
// bias/shift/ReLU/saturate into an unsigned 8-bit feature-map pixel.
// Kernel and bias are loaded serially into a shadow bank and committed to
// the active bank atomically on the write of slot 8.
module conv3x3_mac #(
    parameter int SHIFT  = 0,
    parameter int BIAS_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    conv3x3_mac_if.slave bus
);
    localparam int ACC_W = ((BIAS_W > 21) ? BIAS_W : 21) + 1;

    logic [7:0]               pix [9];
    logic signed [7:0]        wsh_q [9];
    logic signed [7:0]        wact_q [9];
    logic signed [BIAS_W-1:0] bsh_q, bsh_d, bact_q;
    logic [3:0]               idx_q;
    logic                     loaded_q;

    logic                     tok;
    logic signed [16:0]       prod_d [9];
    logic signed [16:0]       prod_q [9];
    logic signed [18:0]       row_d [3];
    logic signed [18:0]       row_q [3];
    logic signed [BIAS_W-1:0] b1_q, b2_q;
    logic                     v1_q, v2_q, v3_q;
    logic signed [20:0]       sum_d;
    logic signed [ACC_W-1:0]  biased_d, shifted_d;
    logic [7:0]               out_d, out_q;

    assign pix[0] = bus.w00;
    assign pix[1] = bus.w01;
    assign pix[2] = bus.w02;
    assign pix[3] = bus.w10;
    assign pix[4] = bus.w11;
    assign pix[5] = bus.w12;
    assign pix[6] = bus.w20;
    assign pix[7] = bus.w21;
    assign pix[8] = bus.w22;

    // A bias written on the commit edge is folded into that commit.
    assign bsh_d = bus.bias_valid ? bus.bias_data : bsh_q;

    // Shadow bank loading and atomic commit to the active bank (ignores en).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 9; k++) begin
                wsh_q[k]  <= '0;
                wact_q[k] <= '0;
            end
            bsh_q    <= '0;
            bact_q   <= '0;
            idx_q    <= '0;
            loaded_q <= 1'b0;
        end else begin
            bsh_q <= bsh_d;
            if (bus.wt_valid) begin
                wsh_q[idx_q] <= bus.wt_data;
                if (idx_q == 4'd8) begin
                    idx_q    <= '0;
                    loaded_q <= 1'b1;
                    bact_q   <= bsh_d;
                    for (int k = 0; k < 8; k++) begin
                        wact_q[k] <= wsh_q[k];
                    end
                    wact_q[8] <= bus.wt_data;
                end else begin
                    idx_q <= idx_q + 4'd1;
                end
            end
        end
    end

    assign tok = bus.en && bus.window_valid && loaded_q;

    // Stage 1 operands: unsigned pixel (zero-extended) times signed weight.
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            prod_d[k] = $signed({8'd0, pix[k]}) * $signed({{9{wact_q[k][7]}}, wact_q[k]});
        end
    end

    // Stage 2 operands: one sum per kernel row.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            row_d[r] = 19'(prod_q[3*r]) + 19'(prod_q[3*r+1]) + 19'(prod_q[3*r+2]);
        end
    end

    // Stage 3 operands: total, bias, arithmetic shift, ReLU and saturation.
    always_comb begin
        sum_d     = 21'(row_q[0]) + 21'(row_q[1]) + 21'(row_q[2]);
        biased_d  = ACC_W'(sum_d) + ACC_W'(b2_q);
        shifted_d = biased_d >>> SHIFT;
        out_d     = shifted_d[7:0];
        if (shifted_d[ACC_W-1]) begin
            out_d = 8'd0;
        end else if (|shifted_d[ACC_W-2:8]) begin
            out_d = 8'd255;
        end
    end

    // Pipeline registers; the whole pipe holds while en is low, and the bias
    // travels with its token so later commits never touch in-flight work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 9; k++) begin
                prod_q[k] <= '0;
            end
            for (int r = 0; r < 3; r++) begin
                row_q[r] <= '0;
            end
            b1_q  <= '0;
            b2_q  <= '0;
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            out_q <= '0;
        end else if (bus.en) begin
            v1_q <= tok;
            if (tok) begin
                for (int k = 0; k < 9; k++) begin
                    prod_q[k] <= prod_d[k];
                end
                b1_q <= bact_q;
            end
            v2_q <= v1_q;
            for (int r = 0; r < 3; r++) begin
                row_q[r] <= row_d[r];
            end
            b2_q <= b1_q;
            v3_q <= v2_q;
            if (v2_q) begin
                out_q <= out_d;
            end
        end
    end

    assign bus.weights_loaded = loaded_q;
    assign bus.wt_idx         = idx_q;
    assign bus.out_pixel      = out_q;
    assign bus.out_valid      = v3_q;
endmodule

// File: tb/tb_conv3x3_mac.sv
// Bench for conv3x3_mac: two instances (SHIFT=0 and SHIFT=3) share stimulus
// and are compared against a token-level arithmetic reference model.
module tb_conv3x3_mac;
    typedef int arr9_t[9];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    conv3x3_mac_if #(.BIAS_W(16)) bus0 ();
    conv3x3_mac_if #(.BIAS_W(16)) bus3 ();

    assign bus3.en           = bus0.en;
    assign bus3.w00          = bus0.w00;
    assign bus3.w01          = bus0.w01;
    assign bus3.w02          = bus0.w02;
    assign bus3.w10          = bus0.w10;
    assign bus3.w11          = bus0.w11;
    assign bus3.w12          = bus0.w12;
    assign bus3.w20          = bus0.w20;
    assign bus3.w21          = bus0.w21;
    assign bus3.w22          = bus0.w22;
    assign bus3.window_valid = bus0.window_valid;
    assign bus3.wt_valid     = bus0.wt_valid;
    assign bus3.wt_data      = bus0.wt_data;
    assign bus3.bias_valid   = bus0.bias_valid;
    assign bus3.bias_data    = bus0.bias_data;

    conv3x3_mac #(.SHIFT(0), .BIAS_W(16)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    conv3x3_mac #(.SHIFT(3), .BIAS_W(16)) u3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    // reference model state
    int         sh_w[9], act_w[9];
    int         sh_b, act_b, m_idx;
    bit         m_loaded;
    bit         pv1, pv2, m_ov;
    logic [7:0] pr1_0, pr1_3, pr2_0, pr2_3, m_op0, m_op3;

    function automatic logic [7:0] ref_px(input arr9_t p, input arr9_t w, input int b, input int sh);
        int acc;
        acc = b;
        for (int k = 0; k < 9; k++) acc += p[k] * w[k];
        acc = acc >>> sh;
        if (acc < 0) return 8'd0;
        if (acc > 255) return 8'd255;
        return 8'(acc);
    endfunction

    function automatic arr9_t cur_pix();
        arr9_t p;
        p[0] = int'(bus0.w00); p[1] = int'(bus0.w01); p[2] = int'(bus0.w02);
        p[3] = int'(bus0.w10); p[4] = int'(bus0.w11); p[5] = int'(bus0.w12);
        p[6] = int'(bus0.w20); p[7] = int'(bus0.w21); p[8] = int'(bus0.w22);
        return p;
    endfunction

    task automatic set_pix(input arr9_t p);
        bus0.w00 = 8'(p[0]); bus0.w01 = 8'(p[1]); bus0.w02 = 8'(p[2]);
        bus0.w10 = 8'(p[3]); bus0.w11 = 8'(p[4]); bus0.w12 = 8'(p[5]);
        bus0.w20 = 8'(p[6]); bus0.w21 = 8'(p[7]); bus0.w22 = 8'(p[8]);
    endtask

    task automatic set_flat(input int v);
        arr9_t p;
        for (int k = 0; k < 9; k++) p[k] = v;
        set_pix(p);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 9; k++) begin
            sh_w[k] = 0;
            act_w[k] = 0;
        end
        sh_b = 0; act_b = 0; m_idx = 0; m_loaded = 0;
        pv1 = 0; pv2 = 0; m_ov = 0;
        pr1_0 = 0; pr1_3 = 0; pr2_0 = 0; pr2_3 = 0; m_op0 = 0; m_op3 = 0;
    endtask

    // One clock edge: advance the model with pre-edge inputs, return at edge+1.
    task automatic tick();
        bit         tk;
        arr9_t      p;
        logic [7:0] r0, r3;
        p  = cur_pix();
        r0 = 0;
        r3 = 0;
        tk = bus0.en && bus0.window_valid && m_loaded;
        if (tk) begin
            r0 = ref_px(p, act_w, act_b, 0);
            r3 = ref_px(p, act_w, act_b, 3);
        end
        @(posedge clk);
        if (bus0.en) begin
            if (pv2) begin
                m_op0 = pr2_0;
                m_op3 = pr2_3;
            end
            m_ov  = pv2;
            pv2   = pv1;
            pr2_0 = pr1_0;
            pr2_3 = pr1_3;
            pv1   = tk;
            if (tk) begin
                pr1_0 = r0;
                pr1_3 = r3;
            end
        end
        if (bus0.bias_valid) sh_b = int'(bus0.bias_data);
        if (bus0.wt_valid) begin
            sh_w[m_idx] = int'(bus0.wt_data);
            if (m_idx == 8) begin
                act_w    = sh_w;
                act_b    = sh_b;
                m_loaded = 1;
                m_idx    = 0;
            end else begin
                m_idx++;
            end
        end
        #1;
    endtask

    task automatic load_kernel(input int w, input int b);
        bus0.window_valid = 1'b0;
        bus0.bias_valid   = 1'b1;
        bus0.bias_data    = 16'(b);
        for (int k = 0; k < 9; k++) begin
            bus0.wt_valid = 1'b1;
            bus0.wt_data  = 8'(w);
            tick();
            bus0.bias_valid = 1'b0;
        end
        bus0.wt_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (bus0.out_pixel !== 8'd0 || bus0.out_valid !== 1'b0 || bus3.out_pixel !== 8'd0 || bus3.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_out: got px=%0d v=%b / px=%0d v=%b, want 0 0", bus0.out_pixel, bus0.out_valid, bus3.out_pixel, bus3.out_valid);
        end
        total++;
        if (bus0.weights_loaded !== 1'b0 || bus0.wt_idx !== 4'd0) begin
            bad++;
            $display("FAIL reset_load: got loaded=%b idx=%0d, want 0 0", bus0.weights_loaded, bus0.wt_idx);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_no_weights();
        bus0.en = 1'b1;
        bus0.window_valid = 1'b1;
        set_flat(10);
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (bus0.out_valid !== 1'b0 || bus3.out_valid !== 1'b0 || m_ov !== 1'b0) begin
                bad++;
                $display("FAIL no_weights: got v=%b/%b, want 0", bus0.out_valid, bus3.out_valid);
            end
        end
        bus0.window_valid = 1'b0;
    endtask

    task automatic test_load_basic();
        bus0.en = 1'b0;
        bus0.window_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            bus0.bias_valid = (k == 0);
            bus0.bias_data  = 16'd0;
            bus0.wt_valid   = 1'b1;
            bus0.wt_data    = 8'd1;
            tick();
            total++;
            if (bus0.wt_idx !== 4'((k + 1) % 9) || bus0.weights_loaded !== (k == 8)) begin
                bad++;
                $display("FAIL load_idx k=%0d: got idx=%0d loaded=%b, want idx=%0d loaded=%b",
                         k, bus0.wt_idx, bus0.weights_loaded, (k + 1) % 9, (k == 8));
            end
        end
        bus0.wt_valid = 1'b0;
        bus0.bias_valid = 1'b0;
        bus0.en = 1'b1;
        set_flat(10);
        for (int i = 0; i < 8; i++) begin
            bit ev;
            bus0.window_valid = (i < 5);
            tick();
            ev = (i >= 2 && i <= 6);
            total++;
            if (bus0.out_valid !== ev || bus3.out_valid !== ev ||
                (ev && (bus0.out_pixel !== 8'd90 || bus3.out_pixel !== 8'd11))) begin
                bad++;
                $display("FAIL burst i=%0d: got v=%b px=%0d/%0d, want v=%b px=90/11",
                         i, bus0.out_valid, bus0.out_pixel, bus3.out_pixel, ev);
            end
        end
        bus0.window_valid = 1'b0;
    endtask

    task automatic test_sat_relu();
        int cw[5]  = '{127, -1, 1, 1, 1};
        int cb[5]  = '{0, 0, 0, -800, -1790};
        int cp[5]  = '{255, 50, 200, 200, 200};
        int e0[5]  = '{255, 0, 255, 255, 10};
        int e3[5]  = '{255, 0, 225, 125, 1};
        for (int c = 0; c < 5; c++) begin
            bus0.en = 1'b0;
            load_kernel(cw[c], cb[c]);
            bus0.en = 1'b1;
            set_flat(cp[c]);
            bus0.window_valid = 1'b1;
            tick();
            bus0.window_valid = 1'b0;
            tick();
            tick();
            total++;
            if (bus0.out_valid !== 1'b1 || bus0.out_pixel !== 8'(e0[c]) || bus3.out_pixel !== 8'(e3[c]) ||
                bus0.out_pixel !== m_op0 || bus3.out_pixel !== m_op3) begin
                bad++;
                $display("FAIL arith case=%0d: got v=%b px=%0d/%0d, want v=1 px=%0d/%0d",
                         c, bus0.out_valid, bus0.out_pixel, bus3.out_pixel, e0[c], e3[c]);
            end
        end
    endtask

    task automatic test_swap();
        bus0.en = 1'b0;
        load_kernel(1, 0);
        bus0.en = 1'b1;
        set_flat(10);
        bus0.window_valid = 1'b1;
        for (int t = 0; t < 16; t++) begin
            bus0.wt_valid   = (t >= 3 && t < 12);
            bus0.wt_data    = 8'd2;
            bus0.bias_valid = (t == 3);
            bus0.bias_data  = 16'd0;
            tick();
            if (t >= 2) begin
                logic [7:0] x0, x3;
                x0 = (t - 2 <= 11) ? 8'd90 : 8'd180;
                x3 = (t - 2 <= 11) ? 8'd11 : 8'd22;
                total++;
                if (bus0.out_valid !== 1'b1 || bus0.out_pixel !== x0 || bus3.out_pixel !== x3) begin
                    bad++;
                    $display("FAIL swap t=%0d: got v=%b px=%0d/%0d, want v=1 px=%0d/%0d",
                             t, bus0.out_valid, bus0.out_pixel, bus3.out_pixel, x0, x3);
                end
            end
        end
        bus0.wt_valid = 1'b0;
        bus0.bias_valid = 1'b0;
        bus0.window_valid = 1'b0;
    endtask

    task automatic test_en_toggle();
        bit         pat[10] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
        logic [7:0] prev_px;
        logic       prev_v;
        bus0.window_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus0.en = pat[c];
            set_flat(5 + c);
            prev_px = bus0.out_pixel;
            prev_v  = bus0.out_valid;
            tick();
            total++;
            if (bus0.out_valid !== m_ov || bus0.out_pixel !== m_op0 ||
                bus3.out_valid !== m_ov || bus3.out_pixel !== m_op3 ||
                (!pat[c] && (bus0.out_pixel !== prev_px || bus0.out_valid !== prev_v))) begin
                bad++;
                $display("FAIL en_toggle c=%0d: got v=%b px=%0d/%0d, want v=%b px=%0d/%0d",
                         c, bus0.out_valid, bus0.out_pixel, bus3.out_pixel, m_ov, m_op0, m_op3);
            end
        end
        bus0.en = 1'b1;
        bus0.window_valid = 1'b0;
    endtask

    task automatic test_random();
        arr9_t p;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 9; k++) p[k] = int'($urandom_range(0, 255));
            set_pix(p);
            bus0.en           = ($urandom_range(0, 3) != 0);
            bus0.window_valid = ($urandom_range(0, 3) != 0);
            bus0.wt_valid     = ($urandom_range(0, 3) == 0);
            bus0.wt_data      = 8'($urandom_range(0, 255));
            bus0.bias_valid   = ($urandom_range(0, 7) == 0);
            bus0.bias_data    = 16'($signed($urandom_range(0, 8000)) - 4000);
            tick();
            total++;
            if (bus0.out_valid !== m_ov || bus0.out_pixel !== m_op0 ||
                bus3.out_valid !== m_ov || bus3.out_pixel !== m_op3 || bus0.wt_idx !== 4'(m_idx)) begin
                bad++;
                $display("FAIL random c=%0d: got v=%b px=%0d/%0d idx=%0d, want v=%b px=%0d/%0d idx=%0d",
                         c, bus0.out_valid, bus0.out_pixel, bus3.out_pixel, bus0.wt_idx, m_ov, m_op0, m_op3, m_idx);
            end
        end
        bus0.wt_valid = 1'b0;
        bus0.bias_valid = 1'b0;
        bus0.window_valid = 1'b0;
    endtask

    task automatic test_reset_midstream();
        arr9_t p;
        bus0.en = 1'b0;
        for (int k = 0; k < 9 && m_idx != 0; k++) begin
            bus0.wt_valid = 1'b1;
            bus0.wt_data  = 8'd1;
            tick();
        end
        load_kernel(1, 0);
        bus0.en = 1'b1;
        bus0.window_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            for (int k = 0; k < 9; k++) p[k] = int'($urandom_range(0, 25));
            set_pix(p);
            bus0.wt_valid = 1'b1;
            bus0.wt_data  = 8'd3;
            tick();
        end
        bus0.wt_valid = 1'b0;
        total++;
        if (bus0.wt_idx !== 4'd5 || bus0.out_valid !== 1'b1 || bus0.out_pixel !== m_op0 || bus3.out_pixel !== m_op3) begin
            bad++;
            $display("FAIL pre_reset: got idx=%0d v=%b px=%0d/%0d, want idx=5 v=1 px=%0d/%0d",
                     bus0.wt_idx, bus0.out_valid, bus0.out_pixel, bus3.out_pixel, m_op0, m_op3);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus0.out_pixel !== 8'd0 || bus0.out_valid !== 1'b0 || bus3.out_pixel !== 8'd0 ||
            bus0.weights_loaded !== 1'b0 || bus0.wt_idx !== 4'd0) begin
            bad++;
            $display("FAIL async_reset: got px=%0d/%0d v=%b loaded=%b idx=%0d, want all 0",
                     bus0.out_pixel, bus3.out_pixel, bus0.out_valid, bus0.weights_loaded, bus0.wt_idx);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_flat(10);
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if (bus0.out_valid !== 1'b0 || bus0.weights_loaded !== 1'b0) begin
                bad++;
                $display("FAIL post_reset_ignore c=%0d: got v=%b loaded=%b, want 0 0", c, bus0.out_valid, bus0.weights_loaded);
            end
        end
        load_kernel(1, 0);
        total++;
        if (bus0.weights_loaded !== 1'b1) begin
            bad++;
            $display("FAIL reload: got loaded=%b, want 1", bus0.weights_loaded);
        end
        set_flat(10);
        bus0.window_valid = 1'b1;
        tick();
        bus0.window_valid = 1'b0;
        tick();
        tick();
        total++;
        if (bus0.out_valid !== 1'b1 || bus0.out_pixel !== 8'd90 || bus3.out_pixel !== 8'd11) begin
            bad++;
            $display("FAIL reload_result: got v=%b px=%0d/%0d, want v=1 px=90/11", bus0.out_valid, bus0.out_pixel, bus3.out_pixel);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus0.en = 1'b0;
        bus0.window_valid = 1'b0;
        bus0.wt_valid = 1'b0;
        bus0.wt_data = 8'd0;
        bus0.bias_valid = 1'b0;
        bus0.bias_data = 16'd0;
        set_flat(0);
        model_reset();
        test_reset();
        test_no_weights();
        test_load_basic();
        test_sat_relu();
        test_swap();
        test_en_toggle();
        test_random();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
